// File: rtl/rca_pkg.sv
// Shared types and helpers for the pipelined ripple-carry / ETM adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rca_pkg;

    // Per-transaction arithmetic mode carried down the pipe with the operands.
    typedef enum logic {
        MODE_EXACT = 1'b0,
        MODE_ETM   = 1'b1
    } mode_e;

    // Number of pipeline stages needed to cover wb bits at seg bits per stage.
    function automatic int rca_nstg(input int wb, input int seg);
        return (wb + seg - 1) / seg;
    endfunction

endpackage

// File: rtl/rca_segment.sv
// One W-bit ripple-carry slice; bits flagged in mask_i are OR-approximated.
// Latency: purely combinational, zero cycles.
// Backpressure: none, the enclosing stage decides when the result is captured.
module rca_segment #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] mask_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    // Ripple through the slice; an approximated bit produces a|b and kills the
    // carry, so the first exact bit above the approximate region starts from 0.
    always_comb begin
        logic c;
        c     = cin_i;
        sum_o = '0;
        for (int i = 0; i < W; i++) begin
            if (mask_i[i]) begin
                sum_o[i] = a_i[i] | b_i[i];
                c        = 1'b0;
            end else begin
                sum_o[i] = a_i[i] ^ b_i[i] ^ c;
                c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
            end
        end
        cout_o = c;
    end

endmodule

// File: rtl/rca_pipe_etm.sv
// Pipelined ripple-carry adder, SEG bits resolved per stage, optional ETM low part.
// Latency: NSTG cycles from accept to out_valid when the output is not stalled.
// Backpressure: valid/ready per stage; a full pipe with out_ready low drops in_ready.
module rca_pipe_etm
    import rca_pkg::*;
#(
    parameter int WA  = 10,
    parameter int WB  = 11,
    parameter int SEG = 4,
    parameter int APX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WA-1:0] in_a,
    input  logic [WB-1:0] in_b,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WB-1:0] out_sum,
    output logic          out_cout
);

    localparam int NSTG = rca_nstg(WB, SEG);

    logic [WB-1:0]   a_ext;
    logic [WB-1:0]   apx_mask;
    logic [NSTG-1:0] vld_q;
    logic [NSTG-1:0] vld_d;
    logic [NSTG-1:0] en;
    logic [NSTG-1:0] load;

    assign a_ext = WB'(in_a);

    // Constant mask of the low bits that ETM mode replaces with a|b.
    always_comb begin
        apx_mask = '0;
        for (int i = 0; i < WB; i++) begin
            apx_mask[i] = (i < APX);
        end
    end

    // Ready chain from the output back to the input: a stage can take new
    // data when it is empty or its content moves on this cycle.
    always_comb begin
        logic free;
        free  = out_ready;
        en    = '0;
        load  = '0;
        vld_d = '0;
        for (int k = NSTG - 1; k >= 0; k--) begin
            free  = ~vld_q[k] | free;
            en[k] = free;
        end
        load[0] = in_valid & rst_n & en[0];
        for (int k = 1; k < NSTG; k++) begin
            load[k] = vld_q[k-1] & en[k];
        end
        for (int k = 0; k < NSTG; k++) begin
            vld_d[k] = load[k] | (vld_q[k] & ~en[k]);
        end
    end

    // Stage occupancy flags; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign in_ready = rst_n & en[0];

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam int HI = ((k + 1) * SEG < WB) ? (k + 1) * SEG : WB;
        localparam int W  = HI - LO;
        localparam int SW = WB - LO;

        // Operand bits still to be added (from bit LO upward), mode and carry-in.
        logic [SW-1:0] src_a;
        logic [SW-1:0] src_b;
        mode_e         src_mode;
        logic          src_cy;
        logic [W-1:0]  seg_mask;
        logic [W-1:0]  seg_sum;
        logic          seg_cout;
        logic [HI-1:0] sum_d;
        logic [HI-1:0] sum_q;
        logic          cy_q;

        if (k == 0) begin : g_src0
            assign src_a    = a_ext;
            assign src_b    = in_b;
            assign src_mode = mode_e'(in_mode);
            assign src_cy   = 1'b0;
            assign sum_d    = seg_sum;
        end else begin : g_srcn
            assign src_a    = g_stg[k-1].g_fwd.ra_q;
            assign src_b    = g_stg[k-1].g_fwd.rb_q;
            assign src_mode = g_stg[k-1].g_fwd.mode_q;
            assign src_cy   = g_stg[k-1].cy_q;
            assign sum_d    = {seg_sum, g_stg[k-1].sum_q};
        end

        assign seg_mask = (src_mode == MODE_ETM) ? apx_mask[HI-1:LO] : '0;

        rca_segment #(
            .W (W)
        ) u_seg (
            .a_i    (src_a[W-1:0]),
            .b_i    (src_b[W-1:0]),
            .mask_i (seg_mask),
            .cin_i  (src_cy),
            .sum_o  (seg_sum),
            .cout_o (seg_cout)
        );

        // Resolved sum bits and carry; the last stage's copy drives the outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                cy_q  <= 1'b0;
            end else if (load[k]) begin
                sum_q <= sum_d;
                cy_q  <= seg_cout;
            end
        end

        if (k < NSTG - 1) begin : g_fwd
            localparam int RW = WB - HI;

            logic [RW-1:0] ra_q;
            logic [RW-1:0] rb_q;
            mode_e         mode_q;

            // Unresolved upper operand bits and mode travel on to the next stage.
            always_ff @(posedge clk) begin
                if (load[k]) begin
                    ra_q   <= src_a[SW-1:W];
                    rb_q   <= src_b[SW-1:W];
                    mode_q <= src_mode;
                end
            end
        end
    end

    assign out_valid = vld_q[NSTG-1];
    assign out_sum   = g_stg[NSTG-1].sum_q;
    assign out_cout  = g_stg[NSTG-1].cy_q;

endmodule

// File: tb/tb_rca_pipe_etm.sv
// Scoreboard bench for rca_pipe_etm: driver pushes expectations, monitor pops on output.
// Latency: checks NSTG-cycle latency on unstalled directed traffic.
// Backpressure: drives fixed, stalled and random out_ready patterns.
module tb_rca_pipe_etm;

    localparam int WA   = 10;
    localparam int WB   = 11;
    localparam int APX  = 4;
    localparam int NSTG = 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [WA-1:0] in_a      = '0;
    logic [WB-1:0] in_b      = '0;
    logic          in_mode   = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WB-1:0] out_sum;
    logic          out_cout;

    always #5 clk = ~clk;

    rca_pipe_etm #(
        .WA  (WA),
        .WB  (WB),
        .SEG (4),
        .APX (APX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    typedef struct {
        int sum;
        int cout;
        int acc;
        bit lat;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    bit   rnd_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact = a+b; ETM = (a|b) on the low APX bits, plus the
    // exact sum of the upper slices (carry-in 0) shifted into place.
    function automatic int model(input int a, input int b, input bit m);
        int lo;
        int hi;
        if (!m) return a + b;
        lo = (a | b) % (1 << APX);
        hi = (a >> APX) + (b >> APX);
        return hi * (1 << APX) + lo;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input int a, input int b, input bit m, input bit lat);
        exp_t e;
        int   r;
        r      = model(a, b, m);
        e.sum  = r % (1 << WB);
        e.cout = r / (1 << WB);
        e.acc  = cyc;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // Present one pair starting at a falling edge; hold it until accepted.
    task automatic send(input int a, input int b, input bit m, input bit lat);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        in_a     = WA'(a);
        in_b     = WB'(b);
        in_mode  = m;
        in_valid = 1'b1;
        while (!done) begin
            #1;
            if (in_ready) begin
                push(a, b, m, lat);
                done = 1'b1;
            end else if (n >= 200) begin
                chk("accept_timeout", int'(in_ready), 1);
                done = 1'b1;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk("drain_left", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: pop and compare on every output handshake, check hold under stall.
    initial begin : mon
        bit   showing;
        bit   held;
        int   since;
        int   h_sum;
        int   h_cout;
        exp_t e;
        showing = 1'b0;
        held    = 1'b0;
        since   = 0;
        h_sum   = 0;
        h_cout  = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                showing = 1'b0;
                held    = 1'b0;
            end else if (out_valid) begin
                if (held) begin
                    chk("hold_sum", int'(out_sum), h_sum);
                    chk("hold_cout", int'(out_cout), h_cout);
                end
                if (!showing) begin
                    showing = 1'b1;
                    since   = cyc;
                end
                if (out_ready) begin
                    showing = 1'b0;
                    held    = 1'b0;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got sum %0d with nothing pending", int'(out_sum));
                    end else begin
                        e = sb.pop_front();
                        chk("sum", int'(out_sum), e.sum);
                        chk("cout", int'(out_cout), e.cout);
                        if (e.lat) chk("latency", since - e.acc, NSTG);
                    end
                end else begin
                    held   = 1'b1;
                    h_sum  = int'(out_sum);
                    h_cout = int'(out_cout);
                end
            end else if (held) begin
                chk("hold_valid", int'(out_valid), 1);
                held    = 1'b0;
                showing = 1'b0;
            end
        end
    end

    initial begin : main
        int  acc;
        bit  fresh;
        int  a;
        int  b;
        bit  m;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_cout", int'(out_cout), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Directed corner pairs, back-to-back with latency checks.
        send(1023, 2047, 1'b0, 1'b1);
        send(15, 1, 1'b1, 1'b1);
        send(15, 1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send(5, 10, i[0], 1'b1);
        for (int i = 0; i < 4; i++) send(12, 4, i[0], 1'b1);
        drain();

        // Eight back-to-back random pairs.
        for (int i = 0; i < 8; i++)
            send(int'($urandom_range(0, 1023)), int'($urandom_range(0, 2047)), bit'($urandom_range(0, 1)), 1'b1);
        drain();

        // Output stall with continuous input: pipe fills to NSTG then blocks.
        out_ready = 1'b0;
        acc       = 0;
        fresh     = 1'b1;
        a         = 0;
        b         = 0;
        m         = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (fresh) begin
                a = int'($urandom_range(0, 1023));
                b = int'($urandom_range(0, 2047));
                m = bit'($urandom_range(0, 1));
                in_a    = WA'(a);
                in_b    = WB'(b);
                in_mode = m;
            end
            #1;
            fresh = in_ready;
            if (in_ready) begin
                push(a, b, m, 1'b0);
                acc++;
            end
            tick();
        end
        #1;
        chk("stall_accepted", acc, NSTG);
        chk("stall_in_ready", int'(in_ready), 0);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        out_ready = 1'b1;
        drain();

        // Reset with two transactions in flight.
        send(100, 200, 1'b0, 1'b0);
        send(300, 400, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_sum", int'(out_sum), 0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        send(1, 1, 1'b0, 1'b1);
        drain();

        // Random traffic against random backpressure.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) != 0) ? 1023 : 0;
                b = ($urandom_range(0, 1) != 0) ? 2047 : 1;
            end else begin
                a = int'($urandom_range(0, 1023));
                b = int'($urandom_range(0, 2047));
            end
            send(a, b, bit'($urandom_range(0, 1)), 1'b0);
        end
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
